// File: rtl/ram_sequencer.sv
// Round-robin arbiter and ADDR/DATA/ACK strobe sequencer that lets two requesters
// share a single 16x8 RAM through a level request / one-cycle ack handshake.
module ram_sequencer #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]         wdata1,
  output logic                     ack0,
  output logic                     ack1,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     ram_mi,
  output logic                     ram_ro,
  output logic                     ram_ri,
  output logic [WIDTH-1:0]         ram_bus_in,
  input  logic [WIDTH-1:0]         ram_bus_out
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  state_t                   state, state_nxt;
  logic                     last;
  logic                     owner;
  logic                     we_l;
  logic [ADDRESS_WIDTH-1:0] addr_l;
  logic [WIDTH-1:0]         wdata_l;
  logic                     any_req;
  logic                     pick;

  // On a tie the port that was not granted most recently wins
  assign any_req = req0 | req1;
  assign pick    = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        owner   <= pick;
        last    <= pick;
        we_l    <= pick ? we1    : we0;
        addr_l  <= pick ? addr1  : addr0;
        wdata_l <= pick ? wdata1 : wdata0;
      end
      if (state == DATA && !we_l) begin
        rdata <= ram_bus_out;
      end
    end
  end

  // Outputs depend only on registered state, so reset clears them asynchronously
  always_comb begin
    state_nxt  = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    ram_mi     = 1'b0;
    ram_ro     = 1'b0;
    ram_ri     = 1'b0;
    ram_bus_in = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (any_req) state_nxt = ADDR;
      ADDR: begin
        ram_mi     = 1'b1;
        ram_bus_in = WIDTH'(addr_l);
        state_nxt  = DATA;
      end
      DATA: begin
        if (we_l) begin
          ram_ri     = 1'b1;
          ram_bus_in = wdata_l;
        end else begin
          ram_ro     = 1'b1;
        end
        state_nxt = ACK;
      end
      ACK: begin
        ack0      = ~owner;
        ack1      = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer: a behavioural RAM behind the strobes and a
// scoreboard of expected acks (port, read data) popped as acks appear.
module tb_ram_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, ram_mi, ram_ro, ram_ri;
  logic [7:0] rdata, ram_bus_in, ram_bus_out;

  ram_sequencer #(.WIDTH(8), .ADDRESS_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_mi(ram_mi), .ram_ro(ram_ro), .ram_ri(ram_ri),
    .ram_bus_in(ram_bus_in), .ram_bus_out(ram_bus_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address latched on ram_mi, written on ram_ri
  logic [7:0] mem [16];
  logic [3:0] ram_addr = 4'h0;
  always @(posedge clk) begin
    if (ram_mi) ram_addr <= ram_bus_in[3:0];
    if (ram_ri) mem[ram_addr] <= ram_bus_in;
  end
  assign ram_bus_out = ram_ro ? mem[ram_addr] : 8'h00;

  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [16];
  logic [7:0] exp_rd;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         a0cnt    = 0;
  int         a1cnt    = 0;
  int         ack_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic push(input logic p, input logic w, input logic [3:0] a);
    if (!w) exp_rd = shadow[a];
    sb.push_back({p, w, exp_rd});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  {ack1, ack0}, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_strb"}, {ram_mi, ram_ro, ram_ri}, 3'b000);
    chk({tag, "_bus"},  ram_bus_in, 8'h00);
    chk({tag, "_rd"},   rdata, 8'h00);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe exclusivity every cycle, scoreboard pop on every ack
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("strobe_onehot", ($countones({ram_mi, ram_ro, ram_ri}) <= 1), 1'b1);
      if (ack0 || ack1) begin
        ack_t.push_back(cyc);
        if (ack0) a0cnt++;
        if (ack1) a1cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_ack", {ack1, ack0}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {ack1, ack0}, e.port ? 2'b10 : 2'b01);
          chk("ack_rdata", rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 8'h00;
      shadow[i] = 8'h00;
    end
    exp_rd = 8'h00;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    #3;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Port 0 write A5 to address 3
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 4'h3; wdata0 = 8'hA5;
    push(1'b0, 1'b1, 4'h3); shadow[3] = 8'hA5;
    @(posedge clk); #1 req0 = 0;
    @(negedge clk);
    chk("w_addr_mi",  {ram_mi, ram_ro, ram_ri}, 3'b100);
    chk("w_addr_bus", ram_bus_in, 8'h03);
    chk("w_addr_busy", busy, 1'b1);
    @(negedge clk);
    chk("w_data_ri",  {ram_mi, ram_ro, ram_ri}, 3'b001);
    chk("w_data_bus", ram_bus_in, 8'hA5);
    @(negedge clk);
    chk("w_ack", {ack1, ack0, busy}, 3'b011);
    @(negedge clk);
    chk("w_idle_busy", busy, 1'b0);

    // Port 1 read back address 3
    @(posedge clk); #1;
    req1 = 1; we1 = 0; addr1 = 4'h3;
    push(1'b1, 1'b0, 4'h3);
    @(posedge clk); #1 req1 = 0;
    @(negedge clk);
    chk("r_addr_bus", ram_bus_in, 8'h03);
    @(negedge clk);
    chk("r_data_ro",  {ram_mi, ram_ro, ram_ri}, 3'b010);
    chk("r_data_bus", ram_bus_in, 8'h00);
    @(negedge clk);
    chk("r_ack", {ack1, ack0}, 2'b10);
    chk("r_rdata", rdata, 8'hA5);

    // Reset, then both ports held for 32 cycles
    @(negedge clk) rst_n = 1'b0; exp_rd = 8'h00;
    @(negedge clk);
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 4'h5; wdata0 = 8'h3C;
    req1 = 1; we1 = 0; addr1 = 4'h5;
    ack_t.delete(); a0cnt = 0; a1cnt = 0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b1, 4'h5); shadow[5] = 8'h3C;
      push(1'b1, 1'b0, 4'h5);
    end
    repeat (32) @(posedge clk);
    #1 req0 = 0; req1 = 0;
    @(negedge clk);
    chk("burst_ack0_cnt", a0cnt, 4);
    chk("burst_ack1_cnt", a1cnt, 4);
    chk("burst_ack_gap", (ack_t.size() >= 2) ? ack_t[1] - ack_t[0] : 0, 4);
    chk("burst_sb_empty", sb.size(), 0);

    // Reset during the DATA cycle of a port 0 write
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 4'h7; wdata0 = 8'h77;
    @(posedge clk); #1 req0 = 0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_rd = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_ack", a0cnt, 4);
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 4'h7; wdata0 = 8'h77;
    push(1'b0, 1'b1, 4'h7); shadow[7] = 8'h77;
    @(posedge clk); #1 req0 = 0;
    repeat (4) @(negedge clk);
    chk("reissue_ack0_cnt", a0cnt, 5);
    chk("reissue_busy", busy, 1'b0);

    // req1 held; req0 arrives mid-access and wins the next IDLE
    @(posedge clk); #1;
    req1 = 1; we1 = 0; addr1 = 4'h7;
    push(1'b1, 1'b0, 4'h7);
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 4'h9; wdata0 = 8'h99;
    push(1'b0, 1'b1, 4'h9); shadow[9] = 8'h99;
    push(1'b1, 1'b0, 4'h7);
    repeat (4) @(posedge clk);
    #1 req0 = 0;
    @(negedge clk);
    chk("mid_req0_addr", {ram_mi, ram_bus_in}, {1'b1, 8'h09});
    repeat (4) @(posedge clk);
    #1 req1 = 0;
    repeat (4) @(negedge clk);
    chk("mid_sb_empty", sb.size(), 0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_mem9", mem[9], 8'h99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_sequencer.md
# ram_sequencer

Two-port arbiter and access sequencer for the shared 16×8 program/data RAM. It lets the CPU control unit (port 0) and the program loader/debug port (port 1) reach the single RAM instance through one request/acknowledge protocol. It also drives the RAM's address-latch, read-enable and write-enable strobes in the required phase order. It sits between the requesters and the `ram` module, replacing direct strobe wiring.

## Interface
- `WIDTH`, 8: data width of RAM words and of both ports.
- `ADDRESS_WIDTH`, 4: RAM address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain only (`clk`).
- `req0` / `req1`  in  1  level access request, port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; sampled with the request.
- `addr0` / `addr1`  in  ADDRESS_WIDTH  word address; sampled with the request.
- `wdata0` / `wdata1`  in  WIDTH  write data; sampled with the request.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  WIDTH  read data, shared by both ports; valid while the owning ack is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `ram_mi`  out  1  RAM address-latch strobe.
- `ram_ro`  out  1  RAM read enable.
- `ram_ri`  out  1  RAM write enable.
- `ram_bus_in`  out  WIDTH  to RAM; carries the zero-extended address during ADDR and the write data during a write DATA phase; 0 otherwise.
- `ram_bus_out`  in  WIDTH  from RAM; read data.

## Operation
- FSM states: IDLE → ADDR → DATA → ACK → IDLE. Each state lasts exactly one cycle except IDLE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If a request is pending, choose the winner, latch its `we`/`addr`/`wdata` into internal registers, update `last`, and go to ADDR.
- **Arbitration** (round-robin on a 1-bit `last` = port most recently granted)
  - Only one port requesting: that port wins.
  - Both requesting: the port ≠ `last` wins.
  - `last` resets to 1, so port 0 wins the first tie.
- **ADDR**
  - `ram_mi` = 1.
  - `ram_bus_in` = {0, latched addr}.
- **DATA, write**
  - `ram_ri` = 1.
  - `ram_bus_in` = latched wdata.
- **DATA, read**
  - `ram_ro` = 1.
  - `rdata` register loads `ram_bus_out` at the end of this cycle.
- **ACK**
  - The owner's `ack` = 1; the other port's ack = 0.
  - `rdata` holds its value until the next read completes; writes do not change it.
- All RAM strobes and acks are decoded from registered state and owner, so there are no combinational paths from `req*` to any output.
- Requests are levels, with no queueing. A req still high in the IDLE cycle after ack counts as a new request.
- Port inputs may change freely after the IDLE sampling cycle; the latched copies are used for the whole access.
- At most one of `ram_mi`, `ram_ro`, `ram_ri` is high in any cycle.

## Timing
- A request is sampled in IDLE cycle N. Then:
  - `ram_mi` is high in cycle N+1.
  - `ram_ro` or `ram_ri` is high in cycle N+2.
  - `ack` and `rdata` are valid in cycle N+3.
  - The FSM is back in IDLE in cycle N+4.
- Access latency is 3 cycles after sampling. Peak throughput is one access per 4 cycles.
- Both ports continuously requesting: grants strictly alternate, and each port is served once every 8 cycles.
- A request arriving while `busy` = 1 is only evaluated at the next IDLE; it is never lost as long as req stays high.
- Reset values:
  - Outputs: `ack0`, `ack1`, `busy`, `ram_mi`, `ram_ro`, `ram_ri`, `ram_bus_in`, `rdata` all 0.
  - Internal: state IDLE; `last` = 1; latched access registers 0.
- Reset asserted mid-access:
  - All strobes drop immediately (asynchronously).
  - The access is abandoned with no ack.
  - A write reset during DATA may or may not have updated RAM; the requester must reissue it.
- Address wrap: ADDRESS_WIDTH bits only; no range checking.

## Test plan
- Port 0 write: req0=1, we0=1, addr0=4'h3, wdata0=8'hA5, port 1 idle → `ram_mi` 1 cycle after sampling with `ram_bus_in`=8'h03, then `ram_ri` with 8'hA5, then ack0 pulse. No ack1, busy=1 for 3 cycles.
- Port 1 read of 8'hA5 at 4'h3 → `ram_ro` in DATA, ack1 with rdata=8'hA5. rdata still 8'hA5 after a subsequent write.
- Simultaneous req0/req1 right after reset → port 0 is served first, then port 1. Acks are 4 cycles apart.
- Both ports held high for 32 cycles → exactly 4 acks each, strictly alternating 0,1,0,1…, and never two strobes high in the same cycle.
- rst_n pulled low during the DATA cycle of a port 0 write → all outputs 0 immediately. After release: state IDLE, `last`=1, no ack0 for the aborted access, and a new req0 completes normally.
- req1 held high continuously with a single req0 pulse arriving mid-access → req0 is granted at the next IDLE (port 1 was `last`), and port 1 resumes afterwards.
